fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side drain for a FIFO with one-cycle read latency. A two-entry skid
// buffer turns FIFO pops into a valid/ready stream without losing words.
module fifo_rd_stream #(
    parameter int SIZE = 8
) (
    input  logic            rclk_i,
    input  logic            rrst_n_i,
    input  logic            en_i,
    input  logic            fifo_empty,
    input  logic [SIZE-1:0] dout,
    output logic            ren,
    output logic            m_valid_o,
    output logic [SIZE-1:0] m_data_o,
    input  logic            m_ready_i,
    output logic [1:0]      occ_o,
    output logic [15:0]     pop_cnt_o
);

    // Stream handshake: a word moves on a rising edge where m_valid_o and
    // m_ready_i are both 1; m_valid_o never drops and m_data_o never changes
    // while the word at the head is waiting for m_ready_i.

    logic            armed_q, armed_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      occ_q, occ_d;
    logic [SIZE-1:0] head_q, head_d;
    logic [SIZE-1:0] tail_q, tail_d;
    logic [15:0]     pop_cnt_q, pop_cnt_d;

    logic            pop_out;
    logic [2:0]      committed;

    // A pop is only issued when the word it returns is guaranteed a slot,
    // counting the word already in flight and the one leaving this cycle.
    always_comb begin
        pop_out   = (occ_q != 2'd0) && m_ready_i;
        committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_out};
        ren       = armed_q && en_i && !fifo_empty && (committed < 3'd2);
    end

    always_comb begin
        armed_d    = 1'b1;
        inflight_d = ren;
        pop_cnt_d  = pop_cnt_q + {15'd0, ren};
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case ({inflight_q, pop_out})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = dout;
                    occ_d  = 2'd1;
                end else begin
                    tail_d = dout;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy holds; the captured word goes behind whatever stays.
                if (occ_q == 2'd1) begin
                    head_d = dout;
                end else begin
                    head_d = tail_q;
                    tail_d = dout;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            armed_q    <= 1'b0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            pop_cnt_q  <= 16'd0;
        end else begin
            armed_q    <= armed_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = head_q;
    assign occ_o     = occ_q;
    assign pop_cnt_o = pop_cnt_q;

endmodule
